// File: rtl/wb_write_arbiter.sv
// Register-file write-port initiator: merges the in-order ALU writeback with a
// FIFO-buffered load-return stream, with starvation relief and hazard reporting.
module wb_write_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  output logic                       alu_stall,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_rd,
  input  logic [XLEN-1:0]            ld_data,
  output logic                       reg_write,
  output logic [4:0]                 rd,
  output logic [XLEN-1:0]            write_data,
  output logic [31:0]                pending_mask,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       proto_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0] aged;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt, starve_nxt;
  logic            stall_nxt;
  logic            nonempty, avail, push, pop, sel_alu, waw;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign fifo_count = count;
  assign ld_ready   = (count != CW'(DEPTH));
  assign nonempty   = (count != '0);
  // An entry becomes poppable only after one full cycle in the FIFO (no bypass).
  assign avail      = nonempty && aged[rd_ptr];
  assign push       = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign sel_alu    = alu_valid && !alu_stall;
  assign pop        = avail && (alu_stall || !alu_valid);
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign waw        = alu_valid && (alu_rd != 5'd0) && pending_mask[alu_rd];

  always_comb begin
    pending_mask = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) pending_mask[fifo_rd[rd_ptr + PW'(k)]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    stall_nxt  = alu_stall;
    if (pop || !nonempty) begin
      starve_nxt = '0;
      stall_nxt  = 1'b0;
    end else if (sel_alu) begin
      starve_nxt = starve_cnt + SW'(1);
    end
    if (!pop && nonempty && (starve_nxt == SW'(STARVE_MAX))) stall_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      aged       <= '0;
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
      proto_err  <= 1'b0;
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        aged[i] <= !(push && (wr_ptr == PW'(i)));
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      starve_cnt <= starve_nxt;
      alu_stall  <= stall_nxt;
      proto_err  <= proto_err | (alu_valid && alu_stall) | waw;
      if (pop) begin
        reg_write  <= (head_rd != 5'd0);
        rd         <= head_rd;
        write_data <= head_data;
      end else if (sel_alu) begin
        reg_write  <= (alu_rd != 5'd0);
        rd         <= alu_rd;
        write_data <= alu_data;
      end else begin
        reg_write  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected port writes are queued as stimulus
// is driven and compared in order whenever the DUT asserts reg_write.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        proto_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [36:0] exp_q[$];

  wb_write_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every port write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && reg_write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, rd, write_data}, 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("sb_write", {27'd0, rd, write_data}, {27'd0, e});
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_wdata", 64'(write_data), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_stall", 64'(alu_stall), 64'd0);
    chk("rst_proto", 64'(proto_err), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ALU-only writes, then rd=0 suppresses the write enable
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    chk("alu_we", 64'(reg_write), 64'd1);
    chk("alu_rd", 64'(rd), 64'd5);
    chk("alu_data", 64'(write_data), 64'hDEADBEEF);
    alu_rd = 5'd0; alu_data = 32'h1234;
    tick();
    chk("alu_rd0_we", 64'(reg_write), 64'd0);
    chk("alu_rd0_rd", 64'(rd), 64'd0);
    alu_valid = 1'b0;
    tick();
    chk("idle_we", 64'(reg_write), 64'd0);

    // Load-only: two back-to-back returns
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h11;
    exp_q.push_back({5'd7, 32'h11});
    tick();
    chk("ld1_mask", 64'(pending_mask), 64'h80);
    chk("ld1_count", 64'(fifo_count), 64'd1);
    ld_rd = 5'd9; ld_data = 32'h22;
    exp_q.push_back({5'd9, 32'h22});
    tick();
    chk("ld2_mask", 64'(pending_mask), 64'h280);
    chk("ld2_count", 64'(fifo_count), 64'd2);
    chk("ld2_no_bypass", 64'(reg_write), 64'd0);
    ld_valid = 1'b0;
    tick();
    chk("ld_pop1_rd", 64'(rd), 64'd7);
    chk("ld_pop1_mask", 64'(pending_mask), 64'h200);
    tick();
    chk("ld_pop2_rd", 64'(rd), 64'd9);
    chk("ld_pop2_mask", 64'(pending_mask), 64'h0);
    chk("ld_pop2_count", 64'(fifo_count), 64'd0);

    // Full FIFO while the ALU (rd=0) keeps winning the port
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = '0;
    ld_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ld_rd = 5'(10 + k); ld_data = 32'(32'h100 + k);
      exp_q.push_back({5'(10 + k), 32'(32'h100 + k)});
      tick();
    end
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_ld_ready", 64'(ld_ready), 64'd0);
    chk("full_mask", 64'(pending_mask), 64'h3C00);
    ld_rd = 5'd20; ld_data = 32'h555;
    tick();
    chk("full_5th_count", 64'(fifo_count), 64'd4);
    chk("full_5th_mask", 64'(pending_mask), 64'h3C00);
    ld_valid = 1'b0; alu_valid = 1'b0;
    repeat (4) tick();
    chk("drain_count", 64'(fifo_count), 64'd0);
    chk("drain_mask", 64'(pending_mask), 64'h0);
    chk("drain_stall", 64'(alu_stall), 64'd0);

    // Starvation: one queued load against continuous ALU traffic
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44;
    tick();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3;
    for (int i = 0; i < 8; i++) begin
      alu_data = 32'(32'h300 + i);
      exp_q.push_back({5'd3, 32'(32'h300 + i)});
      tick();
      if (i < 7) chk("starve_no_stall", 64'(alu_stall), 64'd0);
    end
    chk("starve_stall", 64'(alu_stall), 64'd1);
    alu_valid = 1'b0;
    exp_q.push_back({5'd4, 32'h44});
    tick();
    chk("starve_drain_rd", 64'(rd), 64'd4);
    chk("starve_clear", 64'(alu_stall), 64'd0);
    chk("starve_count", 64'(fifo_count), 64'd0);
    chk("starve_proto", 64'(proto_err), 64'd0);

    // WAW hazard: ALU targets a register with queued load data
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    tick();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA9;
    exp_q.push_back({5'd9, 32'hA9});
    exp_q.push_back({5'd9, 32'h99});
    tick();
    chk("waw_proto", 64'(proto_err), 64'd1);
    chk("waw_alu_data", 64'(write_data), 64'hA9);
    alu_valid = 1'b0;
    tick();
    chk("waw_ld_data", 64'(write_data), 64'h99);
    chk("waw_mask", 64'(pending_mask), 64'h0);

    // Asynchronous reset with loads still queued
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC;
    tick();
    ld_rd = 5'd13; ld_data = 32'hD;
    tick();
    ld_valid = 1'b0;
    chk("pre_rst_count", 64'(fifo_count), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 64'(reg_write), 64'd0);
    chk("arst_rd", 64'(rd), 64'd0);
    chk("arst_wdata", 64'(write_data), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_mask", 64'(pending_mask), 64'd0);
    chk("arst_proto", 64'(proto_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_count", 64'(fifo_count), 64'd0);
    chk("post_rst_we", 64'(reg_write), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
